// File: rtl/repetition_stream_corrector.sv
// Repetition-code majority voter with a one-deep registered valid/ready stage.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_block            REPETITION copies of the data word, copy 0 in the LSBs
//   in_valid, in_ready  upstream handshake (in_ready = !out_valid || out_ready)
//   out_data            majority-voted data word
//   out_error           some copy disagreed with another in some bit
//   out_uncorrectable   some bit had a tied vote (even REPETITION only)
//   out_valid, out_ready downstream handshake
//   error_count         saturating count of errored input blocks
//   error_count_clear   synchronous clear of error_count, wins over increment
//
// The error_count / error_count_clear ports and the counter exist only when
// REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN is defined.

module repetition_stream_corrector #(
    parameter int DATA_WIDTH    = 8,
    parameter int REPETITION    = 3,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [REPETITION*DATA_WIDTH-1:0] in_block,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_error,
    output logic                             out_uncorrectable,
    output logic                             out_valid,
    input  logic                             out_ready
`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
    ,
    output logic [COUNTER_WIDTH-1:0]         error_count,
    input  logic                             error_count_clear
`endif
);

    // Vote counter just wide enough to hold REPETITION.
    localparam int CW = $clog2(REPETITION + 1);
    localparam logic [CW-1:0] REP_C = CW'(REPETITION);
    localparam logic [CW:0]   REP_X = (CW + 1)'(REPETITION);

    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("DATA_WIDTH must be at least 1");
    end
    if (REPETITION < 2) begin : g_bad_repetition
        $error("REPETITION must be at least 2");
    end
    if (COUNTER_WIDTH < 1) begin : g_bad_counter_width
        $error("COUNTER_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] vote_data;
    logic                  vote_error;
    logic                  vote_tie;
    logic [CW-1:0]         ones;
    logic                  in_fire;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;

    // Per-bit vote. Comparing 2*ones against REPETITION avoids the rounding
    // of REPETITION/2 and makes the tie case exact for even REPETITION.
    always_comb begin
        vote_data  = '0;
        vote_error = 1'b0;
        vote_tie   = 1'b0;
        ones       = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ones = '0;
            for (int k = 0; k < REPETITION; k++) begin
                ones = ones + CW'(in_block[k*DATA_WIDTH+i]);
            end
            if ({ones, 1'b0} > REP_X) begin
                vote_data[i] = 1'b1;
            end else if ({ones, 1'b0} == REP_X) begin
                vote_data[i] = in_block[i];
                vote_tie     = 1'b1;
            end else begin
                vote_data[i] = 1'b0;
            end
            if (ones != '0 && ones != REP_C) begin
                vote_error = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_error         <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (in_fire) begin
            out_valid         <= 1'b1;
            out_data          <= vote_data;
            out_error         <= vote_error;
            out_uncorrectable <= vote_tie;
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
    always_ff @(posedge clock) begin
        if (reset || error_count_clear) begin
            error_count <= '0;
        end else if (in_fire && vote_error && error_count != '1) begin
            error_count <= error_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_repetition_stream_corrector.sv
// Self-checking bench for repetition_stream_corrector.
// Covers REPETITION=3 (main instance, scoreboarded) and REPETITION=2.

module tb_repetition_stream_corrector;

    logic        clock;
    logic        reset;
    logic [23:0] in_block;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_error;
    logic        out_uncorrectable;
    logic        out_valid;
    logic        out_ready;

    logic [15:0] in_block2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  out_data2;
    logic        out_error2;
    logic        out_uncorrectable2;
    logic        out_valid2;
    logic        out_ready2;

`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
    logic [1:0]  error_count;
    logic        error_count_clear;
    logic [15:0] error_count2;
    logic        error_count_clear2;
`endif

    repetition_stream_corrector #(
        .DATA_WIDTH(8), .REPETITION(3), .COUNTER_WIDTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_block(in_block),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_error(out_error),
        .out_uncorrectable(out_uncorrectable),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
        ,
        .error_count(error_count),
        .error_count_clear(error_count_clear)
`endif
    );

    repetition_stream_corrector #(
        .DATA_WIDTH(8), .REPETITION(2), .COUNTER_WIDTH(16)
    ) dut2 (
        .clock(clock),
        .reset(reset),
        .in_block(in_block2),
        .in_valid(in_valid2),
        .in_ready(in_ready2),
        .out_data(out_data2),
        .out_error(out_error2),
        .out_uncorrectable(out_uncorrectable2),
        .out_valid(out_valid2),
        .out_ready(out_ready2)
`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
        ,
        .error_count(error_count2),
        .error_count_clear(error_count_clear2)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       unc;
    } exp_t;

    typedef struct {
        logic [23:0] blk;
        logic [7:0]  data;
        logic        err;
        logic        unc;
    } vec3_t;

    typedef struct {
        logic [15:0] blk;
        logic [7:0]  data;
        logic        err;
        logic        unc;
    } vec2_t;

    exp_t  sb[$];
    exp_t  cur_exp;
    int    checks;
    int    errors;
    vec3_t tbl[8];
    vec2_t tbl2[5];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Independent majority model for the 3-copy instance.
    function automatic exp_t model3(input logic [23:0] b);
        exp_t e;
        int   o;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            o = int'(b[i]) + int'(b[i+8]) + int'(b[i+16]);
            e.data[i] = (o >= 2);
            if (o == 1 || o == 2) e.err = 1'b1;
        end
        return e;
    endfunction

    // One clock: evaluate handshakes mid-cycle, score, then advance.
    task automatic step(output logic fired);
        exp_t e;
        #1;
        fired = 1'b0;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_error", 32'(out_error), 32'(e.err));
                chk("out_unc", 32'(out_uncorrectable), 32'(e.unc));
            end
        end
        if (!reset && in_valid && in_ready) begin
            sb.push_back(cur_exp);
            fired = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain();
        logic f;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (sb.size() == 0 && !out_valid) break;
            step(f);
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic        f;
        logic [7:0]  d;
        logic [23:0] base;
        logic [23:0] blks[5];
        int          idx;

        checks = 0;
        errors = 0;

        tbl[0] = '{24'hA5A5A5, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{24'hA5A5A4, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{24'h25A5A5, 8'hA5, 1'b1, 1'b0};
        tbl[3] = '{24'h000000, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{24'hFFFFFF, 8'hFF, 1'b0, 1'b0};
        tbl[5] = '{24'hFF0000, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{24'hFFFF00, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{24'h123456, 8'h16, 1'b1, 1'b0};

        tbl2[0] = '{16'h0F0E, 8'h0E, 1'b1, 1'b1};
        tbl2[1] = '{16'hFFFF, 8'hFF, 1'b0, 1'b0};
        tbl2[2] = '{16'h00FF, 8'hFF, 1'b1, 1'b1};
        tbl2[3] = '{16'h0000, 8'h00, 1'b0, 1'b0};
        tbl2[4] = '{16'h0E0E, 8'h0E, 1'b0, 1'b0};

        reset      = 1'b1;
        in_block   = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_block2  = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        cur_exp    = '0;
`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
        error_count_clear  = 1'b0;
        error_count_clear2 = 1'b0;
`endif

        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_error", 32'(out_error), 32'd0);
        chk("rst_out_unc", 32'(out_uncorrectable), 32'd0);
        chk("rst_out_valid2", 32'(out_valid2), 32'd0);
`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
        chk("rst_count", 32'(error_count), 32'd0);
`endif
        @(negedge clock);

        // Table vectors, back to back.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_block = tbl[i].blk;
            cur_exp  = '{tbl[i].data, tbl[i].err, tbl[i].unc};
            step(f);
            chk("tbl_fire", 32'(f), 32'd1);
        end
        drain();

        // Every single-bit flip over every data value is corrected.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int v = 0; v < 256; v++) begin
            d    = 8'(v);
            base = {d, d, d};
            for (int b = 0; b < 24; b++) begin
                in_block = base ^ (24'h1 << b);
                cur_exp  = '{d, 1'b1, 1'b0};
                step(f);
            end
        end
        drain();

        // Stall for 5 cycles, then stream 4 blocks back to back.
        for (int i = 0; i < 5; i++) blks[i] = 24'($urandom);
        blks[2] = 24'h5A5A5B;
        idx       = 0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_block  = blks[0];
        cur_exp   = model3(blks[0]);
        step(f);
        chk("stall_first_fire", 32'(f), 32'd1);
        in_block = blks[1];
        cur_exp  = model3(blks[1]);
        for (int c = 0; c < 5; c++) begin
            step(f);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(sb[0].data));
            chk("stall_err", 32'(out_error), 32'(sb[0].err));
        end
        out_ready = 1'b1;
        for (idx = 1; idx < 5; idx++) begin
            in_block = blks[idx];
            cur_exp  = model3(blks[idx]);
            step(f);
            chk("stream_fire", 32'(f), 32'd1);
            chk("stream_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Reset while a result is held and not consumed.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_block  = 24'hA5A5A4;
        cur_exp   = model3(24'hA5A5A4);
        step(f);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        step(f);
        sb.delete();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_error", 32'(out_error), 32'd0);
        chk("mid_rst_unc", 32'(out_uncorrectable), 32'd0);
        @(negedge clock);

`ifdef REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN
        // Saturation at 3 and clear priority over increment.
        out_ready         = 1'b1;
        in_valid          = 1'b0;
        error_count_clear = 1'b1;
        step(f);
        error_count_clear = 1'b0;
        chk("cnt_clear", 32'(error_count), 32'd0);
        in_valid = 1'b1;
        in_block = 24'h000001;
        cur_exp  = model3(24'h000001);
        for (int n = 1; n <= 5; n++) begin
            step(f);
            chk("cnt_sat", 32'(error_count), (n > 3) ? 32'd3 : 32'(n));
        end
        error_count_clear = 1'b1;
        step(f);
        error_count_clear = 1'b0;
        chk("cnt_clear_pri", 32'(error_count), 32'd0);
        in_block = 24'hA5A5A5;
        cur_exp  = model3(24'hA5A5A5);
        step(f);
        chk("cnt_clean_hold", 32'(error_count), 32'd0);
        drain();
`endif

        // Two-copy instance: ties keep copy 0 and flag uncorrectable.
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_block2 = tbl2[i].blk;
            @(posedge clock);
            @(negedge clock);
            chk("r2_valid", 32'(out_valid2), 32'd1);
            chk("r2_data", 32'(out_data2), 32'(tbl2[i].data));
            chk("r2_error", 32'(out_error2), 32'(tbl2[i].err));
            chk("r2_unc", 32'(out_uncorrectable2), 32'(tbl2[i].unc));
        end
        in_valid2 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("r2_idle_valid", 32'(out_valid2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/repetition_stream_corrector.md
REPETITION_STREAM_CORRECTOR -- requirements
Module: repetition_stream_corrector

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the protected data word; minimum 1.
REQ-002 Parameter REPETITION, default 3: total copies per block, including the data copy; minimum 2.
REQ-003 Parameter COUNTER_WIDTH, default 16: width of the error counter; minimum 1.
REQ-004 Derived BLOCK_WIDTH = REPETITION*DATA_WIDTH; copy k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; copy 0 (LSBs) is the data.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 in_block  input  BLOCK_WIDTH  received repetition block.
REQ-009 in_valid  input  1  in_block is valid this cycle.
REQ-010 in_ready  output  1  stage accepts in_block this cycle.
REQ-011 out_data  output  DATA_WIDTH  majority-voted data.
REQ-012 out_error  output  1  at least one copy disagreed with another in any bit position.
REQ-013 out_uncorrectable  output  1  at least one bit position has a tied vote.
REQ-014 out_valid  output  1  output register holds a result.
REQ-015 out_ready  input  1  downstream consumes the result this cycle.
REQ-016 error_count  output  COUNTER_WIDTH  saturating count of errored blocks (macro only).
REQ-017 error_count_clear  input  1  synchronous clear of error_count (macro only).

Function
REQ-018 An input transfer occurs when in_valid && in_ready on a rising clock edge; an output transfer occurs when out_valid && out_ready.
REQ-019 The stage is a single registered pipeline stage with latency 1: a block accepted in cycle N is presented on the out_* ports in cycle N+1.
REQ-020 in_ready = !out_valid || out_ready (combinational); in_ready does not depend on in_valid.
REQ-021 The stage sustains full throughput: simultaneous input and output transfers in the same cycle replace the register contents and keep out_valid at 1.
REQ-022 When an output transfer occurs with no input transfer, out_valid clears to 0 on the next edge.
REQ-023 While out_valid && !out_ready, all out_* ports hold stable.
REQ-024 Per bit i, count the ones across the REPETITION copies:
  - ones > REPETITION/2 -> out_data[i] = 1
  - ones < REPETITION/2 -> out_data[i] = 0
  - tie (even REPETITION only) -> out_data[i] = copy-0 bit, and out_uncorrectable is set.
REQ-025 out_error = OR over all bits of (ones != 0 && ones != REPETITION).
REQ-026 For odd REPETITION, out_uncorrectable is constantly 0.
REQ-027 Vote and flag logic is computed before the register; no combinational path exists from in_block to any out_* port.

Reset
REQ-028 Reset drives out_valid=0, out_data=0, out_error=0, out_uncorrectable=0 and error_count=0.
REQ-029 Reset asserted mid-transfer discards the held result; no output transfer completes in the reset cycle.
REQ-030 in_ready is 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro REPETITION_STREAM_CORRECTOR_ERROR_COUNTER_EN, when defined, instantiates error_count and error_count_clear.
REQ-032 With the macro: error_count increments by 1 on each input transfer whose block has out_error true; it saturates at 2^COUNTER_WIDTH-1.
REQ-033 With the macro: error_count_clear has priority over increment and sets error_count to 0.
REQ-034 Without the macro: both ports are absent, no counter flops exist, and all other behaviour is identical.

Verification
REQ-035 DATA_WIDTH=8, REPETITION=3: in_block=24'hA5A5A5 -> next cycle out_data=8'hA5, out_error=0, out_uncorrectable=0.
REQ-036 in_block=24'hA5A5A4 (bit 0 flipped) and 24'h25A5A5 (bit 23 flipped) -> out_data=8'hA5, out_error=1; sweep every single-bit flip over all 256 data values -> always corrected.
REQ-037 REPETITION=2: in_block=16'h0F0E -> out_data=8'h0E, out_error=1, out_uncorrectable=1.
REQ-038 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, no blocks lost; then out_ready=1 for 4 back-to-back blocks -> 4 results in order at one per cycle.
REQ-039 Macro on, COUNTER_WIDTH=2: send 5 errored blocks -> error_count saturates at 3; assert error_count_clear together with an errored transfer -> error_count=0.
REQ-040 Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and in_ready=1, with all outputs at their reset values.
